// File: rtl/pc_cfr_cpg_alloc.sv
// pc_cfr_cpg_alloc: assigns each accepted peak from the peak detector to one of
// NUM_CPG cancellation-pulse-generator channels and runs that channel's
// pulse-ROM address for PULSE_LEN cycles. Peaks with no free channel are
// dropped and counted.
// Optional build macro PC_CFR_CPG_ALLOC_RR_EN: round-robin channel selection
// (default build: fixed priority, lowest free index wins).
module pc_cfr_cpg_alloc #(
    parameter int NUM_CPG    = 4,
    parameter int PULSE_LEN  = 64,
    parameter int DATA_WIDTH = 16,
    parameter int ITERATIONS = 7
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [DATA_WIDTH:0]                   peak_r,
    input  logic [ITERATIONS:0]                   peak_theta,
    input  logic                                  peak_phase,
    input  logic                                  peak_valid,
    input  logic                                  ctrl_enable,
    input  logic                                  stat_clear,
    output logic [NUM_CPG-1:0]                    cpg_valid,
    output logic [NUM_CPG*(DATA_WIDTH+1)-1:0]     cpg_r,
    output logic [NUM_CPG*(ITERATIONS+1)-1:0]     cpg_theta,
    output logic [NUM_CPG-1:0]                    cpg_phase,
    output logic [NUM_CPG*$clog2(PULSE_LEN)-1:0]  cpg_addr,
    output logic [15:0]                           stat_drop_cnt
);

    localparam int AW = $clog2(PULSE_LEN);
    localparam int RW = DATA_WIDTH + 1;
    localparam int TW = ITERATIONS + 1;
    localparam int SW = (NUM_CPG > 1) ? $clog2(NUM_CPG) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(PULSE_LEN - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t        r_state     [NUM_CPG];
    state_t        w_state_nxt [NUM_CPG];
    logic [AW-1:0] r_addr      [NUM_CPG];
    logic [AW-1:0] w_addr_nxt  [NUM_CPG];
    logic [RW-1:0] r_mag       [NUM_CPG];
    logic [RW-1:0] w_mag_nxt   [NUM_CPG];
    logic [TW-1:0] r_theta     [NUM_CPG];
    logic [TW-1:0] w_theta_nxt [NUM_CPG];
    logic          r_slot      [NUM_CPG];
    logic          w_slot_nxt  [NUM_CPG];

    logic [NUM_CPG-1:0] w_free;
    logic [SW-1:0]      w_sel;
    logic               w_found;
    logic               w_req;
    logic               w_accept;
    logic               w_drop;
    logic [15:0]        r_drop_cnt;

    // A channel is free when idle or in the last cycle of its pulse.
    always_comb begin
        for (int k = 0; k < NUM_CPG; k++) begin
            w_free[k] = (r_state[k] == ST_IDLE) || (r_addr[k] == LAST_ADDR);
        end
    end

`ifdef PC_CFR_CPG_ALLOC_RR_EN
    localparam int IW = SW + 1;
    logic [SW-1:0] r_ptr;
    logic [IW-1:0] w_idx;

    // Round-robin search for a free channel starting at the pointer, wrapping.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch is inferred.
        w_sel   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int off = 0; off < NUM_CPG; off++) begin
            w_idx = {1'b0, r_ptr} + IW'(off);
            if (w_idx >= IW'(NUM_CPG)) begin
                w_idx = w_idx - IW'(NUM_CPG);
            end
            if (!w_found && w_free[w_idx[SW-1:0]]) begin
                w_sel   = w_idx[SW-1:0];
                w_found = 1'b1;
            end
        end
    end

    // Pointer moves to one past the channel just allocated.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= (w_sel == SW'(NUM_CPG - 1)) ? '0 : w_sel + SW'(1);
        end
    end
`else
    // Fixed priority: descending scan so the lowest free index is written last.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no latch is inferred.
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = NUM_CPG - 1; k >= 0; k--) begin
            if (w_free[k]) begin
                w_sel   = SW'(k);
                w_found = 1'b1;
            end
        end
    end
`endif

    assign w_req    = peak_valid && ctrl_enable;
    assign w_accept = w_req && w_found;
    assign w_drop   = w_req && !w_found;

    // Per-channel next state: load on selection, count while busy, else idle with zeros.
    always_comb begin
        for (int k = 0; k < NUM_CPG; k++) begin
            w_state_nxt[k] = ST_IDLE;
            w_addr_nxt[k]  = '0;
            w_mag_nxt[k]   = '0;
            w_theta_nxt[k] = '0;
            w_slot_nxt[k]  = 1'b0;
            if (w_accept && (w_sel == SW'(k))) begin
                w_state_nxt[k] = ST_BUSY;
                w_mag_nxt[k]   = peak_r;
                w_theta_nxt[k] = peak_theta;
                w_slot_nxt[k]  = peak_phase;
            end else if ((r_state[k] == ST_BUSY) && (r_addr[k] != LAST_ADDR)) begin
                w_state_nxt[k] = ST_BUSY;
                w_addr_nxt[k]  = r_addr[k] + AW'(1);
                w_mag_nxt[k]   = r_mag[k];
                w_theta_nxt[k] = r_theta[k];
                w_slot_nxt[k]  = r_slot[k];
            end
        end
    end

    // Channel state registers; reset aborts every pulse at once.
    always_ff @(posedge clk) begin
        // NOTE: channel arrays are small flop banks, not RAM, so they are reset like any other register.
        if (rst) begin
            for (int k = 0; k < NUM_CPG; k++) begin
                // NOTE: non-blocking assignments keep all flops updating from the same pre-edge values.
                r_state[k] <= ST_IDLE;
                r_addr[k]  <= '0;
                r_mag[k]   <= '0;
                r_theta[k] <= '0;
                r_slot[k]  <= 1'b0;
            end
        end else begin
            for (int k = 0; k < NUM_CPG; k++) begin
                r_state[k] <= w_state_nxt[k];
                r_addr[k]  <= w_addr_nxt[k];
                r_mag[k]   <= w_mag_nxt[k];
                r_theta[k] <= w_theta_nxt[k];
                r_slot[k]  <= w_slot_nxt[k];
            end
        end
    end

    // Saturating drop counter; clear wins over a simultaneous drop.
    always_ff @(posedge clk) begin
        if (rst || stat_clear) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign stat_drop_cnt = r_drop_cnt;

    for (genvar k = 0; k < NUM_CPG; k++) begin : g_out
        assign cpg_valid[k]             = (r_state[k] == ST_BUSY);
        assign cpg_r[k*RW +: RW]        = r_mag[k];
        assign cpg_theta[k*TW +: TW]    = r_theta[k];
        assign cpg_phase[k]             = r_slot[k];
        assign cpg_addr[k*AW +: AW]     = r_addr[k];
    end

endmodule

// File: tb/tb_pc_cfr_cpg_alloc.sv
// Testbench for pc_cfr_cpg_alloc: timestamp-based channel model compared
// every cycle, directed scenarios with literal expectations, and a random phase.
module tb_pc_cfr_cpg_alloc;

    localparam int N  = 4;
    localparam int PL = 64;
    localparam int DW = 16;
    localparam int IT = 7;
    localparam int AW = 6;
    localparam int RW = DW + 1;
    localparam int TW = IT + 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [DW:0]          peak_r = '0;
    logic [IT:0]          peak_theta = '0;
    logic                 peak_phase = 1'b0;
    logic                 peak_valid = 1'b0;
    logic                 ctrl_enable = 1'b0;
    logic                 stat_clear = 1'b0;
    logic [N-1:0]         cpg_valid;
    logic [N*RW-1:0]      cpg_r;
    logic [N*TW-1:0]      cpg_theta;
    logic [N-1:0]         cpg_phase;
    logic [N*AW-1:0]      cpg_addr;
    logic [15:0]          stat_drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pc_cfr_cpg_alloc #(
        .NUM_CPG(N), .PULSE_LEN(PL), .DATA_WIDTH(DW), .ITERATIONS(IT)
    ) dut (
        .clk(clk), .rst(rst),
        .peak_r(peak_r), .peak_theta(peak_theta), .peak_phase(peak_phase),
        .peak_valid(peak_valid), .ctrl_enable(ctrl_enable), .stat_clear(stat_clear),
        .cpg_valid(cpg_valid), .cpg_r(cpg_r), .cpg_theta(cpg_theta),
        .cpg_phase(cpg_phase), .cpg_addr(cpg_addr), .stat_drop_cnt(stat_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: each pulse is a start timestamp ----------------
    typedef struct {
        bit          act;
        int          start;
        logic [DW:0] r;
        logic [IT:0] th;
        logic        ph;
    } ch_t;

    ch_t m_ch [N];
    int  m_cyc  = 0;
    int  m_drop = 0;
    int  m_ptr  = 0;

    always begin
        bit fr [N];
        int sel;
        bit req;
        logic [N-1:0]    e_valid;
        logic [N*RW-1:0] e_r;
        logic [N*TW-1:0] e_th;
        logic [N-1:0]    e_ph;
        logic [N*AW-1:0] e_addr;
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < N; k++) m_ch[k] = '{0, 0, '0, '0, 1'b0};
            m_drop = 0;
            m_ptr  = 0;
        end else begin
            for (int k = 0; k < N; k++)
                fr[k] = !m_ch[k].act || (m_cyc - m_ch[k].start == PL - 1);
            sel = -1;
`ifdef PC_CFR_CPG_ALLOC_RR_EN
            for (int o = 0; o < N; o++)
                if (sel < 0 && fr[(m_ptr + o) % N]) sel = (m_ptr + o) % N;
`else
            for (int k = 0; k < N; k++)
                if (sel < 0 && fr[k]) sel = k;
`endif
            for (int k = 0; k < N; k++)
                if (m_ch[k].act && (m_cyc - m_ch[k].start == PL - 1)) m_ch[k].act = 0;
            req = peak_valid && ctrl_enable;
            if (req && sel >= 0) begin
                m_ch[sel] = '{1, m_cyc + 1, peak_r, peak_theta, peak_phase};
                m_ptr = (sel + 1) % N;
            end
            if (stat_clear) m_drop = 0;
            else if (req && sel < 0 && m_drop < 65535) m_drop++;
        end
        m_cyc++;
        #1;
        for (int k = 0; k < N; k++) begin
            e_valid[k]          = m_ch[k].act;
            e_r[k*RW +: RW]     = m_ch[k].act ? m_ch[k].r  : '0;
            e_th[k*TW +: TW]    = m_ch[k].act ? m_ch[k].th : '0;
            e_ph[k]             = m_ch[k].act ? m_ch[k].ph : 1'b0;
            e_addr[k*AW +: AW]  = m_ch[k].act ? AW'(m_cyc - m_ch[k].start) : '0;
        end
        check("cmp_valid", 128'(cpg_valid), 128'(e_valid));
        check("cmp_r",     128'(cpg_r),     128'(e_r));
        check("cmp_theta", 128'(cpg_theta), 128'(e_th));
        check("cmp_phase", 128'(cpg_phase), 128'(e_ph));
        check("cmp_addr",  128'(cpg_addr),  128'(e_addr));
        check("cmp_drop",  128'(stat_drop_cnt), 128'(m_drop));
    end

    // ---------------- stimulus helpers (inputs change just after negedge) ----------------
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; peak_valid = 1'b0; stat_clear = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Presents one peak for one cycle; returns at the negedge where the allocation is visible.
    task automatic send_peak(input logic [DW:0] r, input logic [IT:0] th, input logic ph);
        peak_r = r; peak_theta = th; peak_phase = ph; peak_valid = 1'b1;
        @(negedge clk);
        peak_valid = 1'b0;
    endtask

    logic [N-1:0] exp_ch;

    initial begin
        ctrl_enable = 1'b1;
        do_reset();
        check("rst_valid", 128'(cpg_valid), 128'(0));
        check("rst_addr",  128'(cpg_addr),  128'(0));
        check("rst_drop",  128'(stat_drop_cnt), 128'(0));

        // Test 1: single peak occupies channel 0 for exactly 64 cycles.
        send_peak(17'h123, 8'h45, 1'b1);
        check("t1_valid0", 128'(cpg_valid), 128'(4'b0001));
        check("t1_addr0",  128'(cpg_addr[5:0]), 128'(0));
        check("t1_r0",     128'(cpg_r[16:0]), 128'(17'h123));
        check("t1_theta0", 128'(cpg_theta[7:0]), 128'(8'h45));
        check("t1_phase0", 128'(cpg_phase[0]), 128'(1));
        repeat (63) @(negedge clk);
        check("t1_last_valid", 128'(cpg_valid[0]), 128'(1));
        check("t1_last_addr",  128'(cpg_addr[5:0]), 128'(63));
        @(negedge clk);
        check("t1_end_valid", 128'(cpg_valid), 128'(0));
        check("t1_end_r",     128'(cpg_r), 128'(0));
        check("t1_end_theta", 128'(cpg_theta), 128'(0));

        // Test 2: five peaks two cycles apart -> channels 0..3 then a drop.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_peak(17'(i + 1), 8'(i * 3), 1'(i));
            exp_ch = (i < 4) ? 4'((1 << (i + 1)) - 1) : 4'hF;
            check("t2_valid", 128'(cpg_valid), 128'(exp_ch));
            check("t2_addr0", 128'(cpg_addr[5:0]), 128'(2 * i));
            @(negedge clk);
        end
        check("t2_drop", 128'(stat_drop_cnt), 128'(1));

        // Test 3: peak arriving in channel 0's last cycle re-selects it without a gap.
        do_reset();
        send_peak(17'h011, 8'h01, 1'b0);
        send_peak(17'h022, 8'h02, 1'b0);
        send_peak(17'h033, 8'h03, 1'b0);
        send_peak(17'h044, 8'h04, 1'b0);
        repeat (60) @(negedge clk);
        check("t3_pre_addr0", 128'(cpg_addr[5:0]), 128'(63));
        send_peak(17'h1AB, 8'h77, 1'b1);
        check("t3_valid",  128'(cpg_valid), 128'(4'hF));
        check("t3_addr0",  128'(cpg_addr[5:0]), 128'(0));
        check("t3_r0",     128'(cpg_r[16:0]), 128'(17'h1AB));
        check("t3_drop",   128'(stat_drop_cnt), 128'(0));

        // Test 4: disabled peaks are ignored; disabling mid-pulse does not truncate.
        do_reset();
        ctrl_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send_peak(17'h0AA, 8'h10, 1'b0);
            @(negedge clk);
        end
        check("t4_no_alloc", 128'(cpg_valid), 128'(0));
        check("t4_no_drop",  128'(stat_drop_cnt), 128'(0));
        ctrl_enable = 1'b1;
        send_peak(17'h0BB, 8'h20, 1'b1);
        repeat (10) @(negedge clk);
        ctrl_enable = 1'b0;
        send_peak(17'h0CC, 8'h30, 1'b0);
        repeat (52) @(negedge clk);
        check("t4_hold_valid", 128'(cpg_valid), 128'(4'b0001));
        check("t4_hold_addr",  128'(cpg_addr[5:0]), 128'(63));
        @(negedge clk);
        check("t4_done", 128'(cpg_valid), 128'(0));
        ctrl_enable = 1'b1;

        // Test 6: isolated peaks after each pulse ends.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send_peak(17'(i + 5), 8'(i), 1'b0);
`ifdef PC_CFR_CPG_ALLOC_RR_EN
            exp_ch = 4'(1 << i);
`else
            exp_ch = 4'b0001;
`endif
            check("t6_chan", 128'(cpg_valid), 128'(exp_ch));
            repeat (70) @(negedge clk);
        end

        // Test 5a: reset mid-pulse clears everything next cycle.
        do_reset();
        send_peak(17'h101, 8'h11, 1'b1);
        send_peak(17'h102, 8'h12, 1'b0);
        send_peak(17'h103, 8'h13, 1'b1);
        repeat (30) @(negedge clk);
        check("t5_addr2", 128'(cpg_addr[17:12]), 128'(30));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_valid", 128'(cpg_valid), 128'(0));
        check("t5_rst_addr",  128'(cpg_addr),  128'(0));
        check("t5_rst_r",     128'(cpg_r),     128'(0));
        check("t5_rst_theta", 128'(cpg_theta), 128'(0));

        // Random phase.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            peak_valid  = ($urandom_range(0, 99) < 40);
            peak_r      = 17'($urandom);
            peak_theta  = 8'($urandom);
            peak_phase  = 1'($urandom);
            ctrl_enable = ($urandom_range(0, 9) != 0);
            stat_clear  = ($urandom_range(0, 49) == 0);
            rst         = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        rst = 1'b0; stat_clear = 1'b0; peak_valid = 1'b0; ctrl_enable = 1'b1;

        // Test 5b: drop counter saturation and clear priority.
        do_reset();
        peak_valid = 1'b1;
        for (int i = 0; i < 80000 && stat_drop_cnt != 16'hFFFF; i++) begin
            peak_r = 17'(i);
            @(negedge clk);
        end
        check("t5_sat_reach", 128'(stat_drop_cnt), 128'(16'hFFFF));
        repeat (8) @(negedge clk);
        check("t5_sat_hold", 128'(stat_drop_cnt), 128'(16'hFFFF));
        stat_clear = 1'b1;
        @(negedge clk);
        stat_clear = 1'b0;
        peak_valid = 1'b0;
        check("t5_clear", 128'(stat_drop_cnt), 128'(0));
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
